// File: rtl/ahb_master_mux.sv
// rtl/ahb_master_mux.sv - AHB master-side address/data multiplexer with burst tracking
//
// Selects the address-phase master (Hmaster) onto the shared bus, keeps a
// data-phase master register so write data and responses follow the AHB
// pipeline, and counts fixed-length burst beats so the arbiter can hold grant.
//
// Ports:
//   Hclk, Hreset            clock, synchronous active-high reset
//   Hmaster                 address-phase owner from the arbiter
//   Haddr_m .. Hwdata_m     per-master request fields, master i at slice i
//   Hready, Hresp           slave-side ready and response
//   Haddr .. Hburst         muxed address-phase fields
//   Hwdata                  write data of the data-phase master
//   Hresp_m                 per-master response (OKAY unless in data phase)
//   Hburst_active           fixed-length burst has beats remaining
//   Hebt                    one-cycle early burst termination pulse
//   Hprot_err               sticky protocol error
//
// Optional feature macro: AHB_MUX_PROT_CHECK_EN (protocol checker for Hprot_err).

module ahb_master_mux #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                              Hclk,
    input  logic                              Hreset,
    input  logic [MW-1:0]                     Hmaster,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] Haddr_m,
    input  logic [NUM_MASTERS*2-1:0]          Htrans_m,
    input  logic [NUM_MASTERS-1:0]            Hwrite_m,
    input  logic [NUM_MASTERS*3-1:0]          Hsize_m,
    input  logic [NUM_MASTERS*3-1:0]          Hburst_m,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] Hwdata_m,
    input  logic                              Hready,
    input  logic [1:0]                        Hresp,
    output logic [ADDR_WIDTH-1:0]             Haddr,
    output logic [1:0]                        Htrans,
    output logic                              Hwrite,
    output logic [2:0]                        Hsize,
    output logic [2:0]                        Hburst,
    output logic [DATA_WIDTH-1:0]             Hwdata,
    output logic [NUM_MASTERS*2-1:0]          Hresp_m,
    output logic                              Hburst_active,
    output logic                              Hebt,
    output logic                              Hprot_err
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;
    localparam logic [1:0] RESP_ERROR   = 2'b01;

    logic [MW-1:0] dmaster;
    logic          dvalid;
    logic [4:0]    beats_left;
    logic [4:0]    burst_len;
    logic          acc_nonseq;
    logic          acc_seq;
    logic          early_term;

    // Address-phase mux; an out-of-range Hmaster leaves the bus IDLE with zeros.
    always_comb begin
        Haddr  = '0;
        Htrans = TRANS_IDLE;
        Hwrite = 1'b0;
        Hsize  = 3'b000;
        Hburst = 3'b000;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (Hmaster == MW'(i)) begin
                Haddr  = Haddr_m[i*ADDR_WIDTH +: ADDR_WIDTH];
                Htrans = Htrans_m[i*2 +: 2];
                Hwrite = Hwrite_m[i];
                Hsize  = Hsize_m[i*3 +: 3];
                Hburst = Hburst_m[i*3 +: 3];
            end
        end
    end

    // Data-phase mux follows the registered data-phase owner.
    always_comb begin
        Hwdata  = '0;
        Hresp_m = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (dmaster == MW'(i)) begin
                Hwdata = Hwdata_m[i*DATA_WIDTH +: DATA_WIDTH];
                if (dvalid) begin
                    Hresp_m[i*2 +: 2] = Hresp;
                end
            end
        end
    end

    always_comb begin
        case (Hburst)
            3'b010, 3'b011: burst_len = 5'd4;
            3'b100, 3'b101: burst_len = 5'd8;
            3'b110, 3'b111: burst_len = 5'd16;
            default:        burst_len = 5'd0;
        endcase
    end

    assign acc_nonseq = Hready && (Htrans == TRANS_NONSEQ);
    assign acc_seq    = Hready && (Htrans == TRANS_SEQ);
    assign early_term = (beats_left != 5'd0) &&
                        ((Hready && (Htrans == TRANS_IDLE)) ||
                         (dvalid && (Hresp == RESP_ERROR)));

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            dmaster    <= '0;
            dvalid     <= 1'b0;
            beats_left <= 5'd0;
            Hebt       <= 1'b0;
        end else begin
            if (Hready) begin
                dmaster <= Hmaster;
                dvalid  <= Htrans[1];
            end
            Hebt <= 1'b0;
            // A new NONSEQ restarts the count even if the old burst is being
            // terminated in the same cycle; that case does not pulse Hebt.
            if (acc_nonseq) begin
                beats_left <= (burst_len == 5'd0) ? 5'd0 : burst_len - 5'd1;
            end else if (early_term) begin
                beats_left <= 5'd0;
                Hebt       <= 1'b1;
            end else if (acc_seq && (beats_left != 5'd0)) begin
                beats_left <= beats_left - 5'd1;
            end
        end
    end

    assign Hburst_active = (beats_left != 5'd0);

`ifdef AHB_MUX_PROT_CHECK_EN
    logic [MW-1:0] owner;
    logic          last_incr;
    logic          prot_err;

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            owner     <= '0;
            last_incr <= 1'b0;
            prot_err  <= 1'b0;
        end else begin
            if (acc_nonseq) begin
                owner     <= Hmaster;
                last_incr <= (Hburst == 3'b001);
            end
            // SEQ outside any burst (undefined-length INCR excepted), or SEQ
            // from a master other than the one that opened the burst.
            if (acc_seq &&
                (((beats_left == 5'd0) && !last_incr) ||
                 ((beats_left != 5'd0) && (Hmaster != owner)))) begin
                prot_err <= 1'b1;
            end
        end
    end

    assign Hprot_err = prot_err;
`else
    assign Hprot_err = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_master_mux.sv
// tb/tb_ahb_master_mux.sv - self-checking bench for ahb_master_mux
module tb_ahb_master_mux;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            Hclk = 1'b0;
    logic            Hreset;
    logic [1:0]      Hmaster;
    logic [N*AW-1:0] Haddr_m;
    logic [N*2-1:0]  Htrans_m;
    logic [N-1:0]    Hwrite_m;
    logic [N*3-1:0]  Hsize_m;
    logic [N*3-1:0]  Hburst_m;
    logic [N*DW-1:0] Hwdata_m;
    logic            Hready;
    logic [1:0]      Hresp;
    logic [AW-1:0]   Haddr;
    logic [1:0]      Htrans;
    logic            Hwrite;
    logic [2:0]      Hsize;
    logic [2:0]      Hburst;
    logic [DW-1:0]   Hwdata;
    logic [N*2-1:0]  Hresp_m;
    logic            Hburst_active;
    logic            Hebt;
    logic            Hprot_err;

    logic [31:0] a_m [N];
    logic [1:0]  t_m [N];
    logic        w_m [N];
    logic [2:0]  s_m [N];
    logic [2:0]  b_m [N];
    logic [31:0] d_m [N];

    always_comb begin
        Haddr_m = '0; Htrans_m = '0; Hwrite_m = '0;
        Hsize_m = '0; Hburst_m = '0; Hwdata_m = '0;
        for (int i = 0; i < N; i++) begin
            Haddr_m[i*AW +: AW] = a_m[i];
            Htrans_m[i*2 +: 2]  = t_m[i];
            Hwrite_m[i]         = w_m[i];
            Hsize_m[i*3 +: 3]   = s_m[i];
            Hburst_m[i*3 +: 3]  = b_m[i];
            Hwdata_m[i*DW +: DW] = d_m[i];
        end
    end

    ahb_master_mux #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .Hclk(Hclk), .Hreset(Hreset), .Hmaster(Hmaster),
        .Haddr_m(Haddr_m), .Htrans_m(Htrans_m), .Hwrite_m(Hwrite_m),
        .Hsize_m(Hsize_m), .Hburst_m(Hburst_m), .Hwdata_m(Hwdata_m),
        .Hready(Hready), .Hresp(Hresp),
        .Haddr(Haddr), .Htrans(Htrans), .Hwrite(Hwrite), .Hsize(Hsize),
        .Hburst(Hburst), .Hwdata(Hwdata), .Hresp_m(Hresp_m),
        .Hburst_active(Hburst_active), .Hebt(Hebt), .Hprot_err(Hprot_err)
    );

    always #5 Hclk = ~Hclk;

    int checks = 0;
    int fails  = 0;

    // Reference model: what the bus has promised so far, in plain integers.
    int m_dm, m_beats, m_owner;
    bit m_dv, m_ebt, m_perr, m_lastincr;

    function automatic int blen(input logic [2:0] b);
        int v = int'(b);
        if (v < 2) return 0;
        return 1 << ((v >> 1) + 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int hm = int'(Hmaster);
        logic [7:0] er = 8'h00;
        #1;
        if (m_dv) er[m_dm*2 +: 2] = Hresp;
        chk("haddr",   Haddr,  a_m[hm]);
        chk("htrans",  Htrans, t_m[hm]);
        chk("hwrite",  Hwrite, w_m[hm]);
        chk("hsize",   Hsize,  s_m[hm]);
        chk("hburst",  Hburst, b_m[hm]);
        chk("hwdata",  Hwdata, d_m[m_dm]);
        chk("hresp_m", Hresp_m, er);
        chk("active",  Hburst_active, (m_beats > 0) ? 1 : 0);
        chk("hebt",    Hebt, m_ebt);
        chk("prot",    Hprot_err, m_perr);
    endtask

    task automatic model_update();
        int hm = int'(Hmaster);
        logic [1:0] t = t_m[hm];
        bit dv_old = m_dv;
        if (Hreset) begin
            m_dm = 0; m_dv = 0; m_beats = 0; m_owner = 0;
            m_ebt = 0; m_perr = 0; m_lastincr = 0;
            return;
        end
`ifdef AHB_MUX_PROT_CHECK_EN
        if (Hready && t == 2'b11 &&
            ((m_beats == 0 && !m_lastincr) || (m_beats > 0 && hm != m_owner)))
            m_perr = 1;
`endif
        if (Hready) begin m_dm = hm; m_dv = t[1]; end
        m_ebt = 0;
        if (Hready && t == 2'b10) begin
            m_beats    = (blen(b_m[hm]) > 0) ? blen(b_m[hm]) - 1 : 0;
            m_owner    = hm;
            m_lastincr = (b_m[hm] == 3'b001);
        end else if (m_beats > 0 && ((Hready && t == 2'b00) || (dv_old && Hresp == 2'b01))) begin
            m_beats = 0;
            m_ebt   = 1;
        end else if (Hready && t == 2'b11 && m_beats > 0) begin
            m_beats--;
        end
    endtask

    task automatic tick();
        check_outputs();
        @(posedge Hclk);
        #1;
        model_update();
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) begin
            a_m[i] = $urandom; t_m[i] = 2'b00; w_m[i] = 1'b0;
            s_m[i] = 3'b010;   b_m[i] = 3'b000; d_m[i] = $urandom;
        end
    endtask

    task automatic drive(input int m, input logic [1:0] t, input logic [2:0] b,
                         input logic [31:0] a, input logic [31:0] d);
        idle_all();
        Hmaster = 2'(m);
        t_m[m] = t; b_m[m] = b; a_m[m] = a; d_m[m] = d; w_m[m] = 1'b1;
    endtask

    initial begin
        Hreset = 1'b1; Hready = 1'b1; Hresp = 2'b00; Hmaster = 2'd0;
        idle_all();
        @(posedge Hclk); #1; model_update();
        tick();
        // Reset state
        chk("rst_active", Hburst_active, 0);
        chk("rst_hebt",   Hebt, 0);
        chk("rst_prot",   Hprot_err, 0);
        chk("rst_resp",   Hresp_m, 0);

        // Reset held 3 cycles in the middle of an INCR4
        Hreset = 1'b0;
        drive(1, 2'b10, 3'b011, 32'h40, 32'h1); tick();
        drive(1, 2'b11, 3'b011, 32'h44, 32'h2); tick();
        Hreset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'b11, 3'b011, 32'h48, 32'h3); tick();
        end
        chk("midrst_active", Hburst_active, 0);
        chk("midrst_hebt",   Hebt, 0);
        Hreset = 1'b0;

        // Single write from master 2
        drive(2, 2'b10, 3'b000, 32'h100, 32'hA5A5A5A5);
        #1 chk("single_haddr", Haddr, 32'h100);
        tick();
        drive(0, 2'b00, 3'b000, 32'h0, 32'h0);
        d_m[2] = 32'hA5A5A5A5; Hresp = 2'b10;
        #1 chk("single_wdata", Hwdata, 32'hA5A5A5A5);
        chk("single_resp", Hresp_m, 8'h20);
        tick();
        Hresp = 2'b00;

        // INCR4 by master 1, no waits
        for (int beat = 0; beat < 4; beat++) begin
            drive(1, (beat == 0) ? 2'b10 : 2'b11, 3'b011, 32'h200 + 4*beat, $urandom);
            tick();
            chk("incr4_active", Hburst_active, (beat < 3) ? 1 : 0);
            chk("incr4_hebt", Hebt, 0);
        end

        // INCR4 with two wait states on beat 2: six address cycles
        for (int c = 0; c < 6; c++) begin
            drive(1, (c == 0) ? 2'b10 : 2'b11, 3'b011, 32'h300, $urandom);
            Hready = (c == 1 || c == 2) ? 1'b0 : 1'b1;
            tick();
            chk("wait_active", Hburst_active, (c < 5) ? 1 : 0);
        end
        Hready = 1'b1;

        // INCR8 by master 3, IDLE after beat 3
        for (int beat = 0; beat < 3; beat++) begin
            drive(3, (beat == 0) ? 2'b10 : 2'b11, 3'b101, 32'h400 + 4*beat, $urandom);
            tick();
        end
        drive(3, 2'b00, 3'b101, 32'h0, 32'h0); tick();
        chk("ebt_pulse",  Hebt, 1);
        chk("ebt_active", Hburst_active, 0);
        tick();
        chk("ebt_clear",  Hebt, 0);

        // ERROR response at beat 2 of WRAP4
        drive(1, 2'b10, 3'b010, 32'h500, $urandom); tick();
        drive(1, 2'b11, 3'b010, 32'h504, $urandom); tick();
        drive(1, 2'b11, 3'b010, 32'h508, $urandom); Hready = 1'b0; Hresp = 2'b01; tick();
        chk("err_hebt",   Hebt, 1);
        chk("err_active", Hburst_active, 0);
        drive(1, 2'b00, 3'b010, 32'h0, $urandom); Hready = 1'b1; tick();
        chk("err_hebt2",  Hebt, 0);
        Hresp = 2'b00;

        // SEQ from master 0 during master 1's burst
        drive(1, 2'b10, 3'b011, 32'h600, $urandom); tick();
        drive(0, 2'b11, 3'b011, 32'h604, $urandom); tick();
`ifdef AHB_MUX_PROT_CHECK_EN
        chk("prot_handover", Hprot_err, 1);
`else
        chk("prot_handover", Hprot_err, 0);
`endif
        drive(0, 2'b00, 3'b000, 32'h0, $urandom); tick();

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                a_m[i] = $urandom; t_m[i] = 2'($urandom_range(0, 3));
                w_m[i] = 1'($urandom); s_m[i] = 3'($urandom);
                b_m[i] = 3'($urandom); d_m[i] = $urandom;
            end
            Hmaster = 2'($urandom_range(0, 3));
            Hready  = ($urandom_range(0, 3) != 0);
            Hresp   = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'($urandom_range(0, 3));
            Hreset  = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
